// File: rtl/aximm_burst_writer.sv
// rtl/aximm_burst_writer.sv - AXI stream to AXI4 INCR write-burst sequencer
module aximm_burst_writer #(
    parameter int DW              = 512,
    parameter int AW              = 64,
    parameter int MAX_BEATS       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [31:0]     total_beats,
    output logic            busy,
    output logic            done,
    output logic            error,
    input  logic [DW-1:0]   AXIS_IN_TDATA,
    input  logic            AXIS_IN_TVALID,
    output logic            AXIS_IN_TREADY,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);
    localparam int BYTES  = DW / 8;
    localparam int BSHIFT = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [31:0]   remaining;
    logic [8:0]    beat_cnt;
    logic [3:0]    outstanding;
    logic [3:0]    outstanding_next;
    logic [31:0]   boundary_beats;
    logic [31:0]   len;
    logic          aw_hs;
    logic          w_hs;
    logic          b_hs;

    // Burst length: capped by MAX_BEATS, what is left, and the beats up to the next 4 KB page.
    always_comb begin
        boundary_beats = (32'd4096 - {20'd0, addr[11:0]}) >> BSHIFT;
        len = 32'(MAX_BEATS);
        if (remaining < len)
            len = remaining;
        if (boundary_beats < len)
            len = boundary_beats;
    end

    assign M_AXI_AWVALID  = (state == ADDR) && (outstanding < 4'(MAX_OUTSTANDING));
    assign M_AXI_AWADDR   = addr;
    assign M_AXI_AWLEN    = 8'(len - 32'd1);
    assign M_AXI_AWSIZE   = 3'(BSHIFT);
    assign M_AXI_AWBURST  = 2'b01;
    assign M_AXI_WVALID   = (state == DATA) && AXIS_IN_TVALID;
    assign AXIS_IN_TREADY = (state == DATA) && M_AXI_WREADY;
    assign M_AXI_WDATA    = AXIS_IN_TDATA;
    assign M_AXI_WSTRB    = '1;
    assign M_AXI_WLAST    = (state == DATA) && (beat_cnt == 9'd1);

    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
    // A response with nothing outstanding is stray and must not underflow the count.
    assign b_hs  = M_AXI_BVALID && M_AXI_BREADY && (outstanding != 4'd0);

    always_comb begin
        outstanding_next = outstanding;
        if (aw_hs && !b_hs)
            outstanding_next = outstanding + 4'd1;
        else if (b_hs && !aw_hs)
            outstanding_next = outstanding - 4'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            addr         <= '0;
            remaining    <= '0;
            beat_cnt     <= '0;
            outstanding  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            M_AXI_BREADY <= 1'b0;
        end else begin
            M_AXI_BREADY <= 1'b1;
            done         <= 1'b0;
            outstanding  <= outstanding_next;
            if (b_hs && (M_AXI_BRESP != 2'b00))
                error <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr & ~AW'(BYTES - 1);
                        remaining <= total_beats;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (total_beats == 32'd0) ? DRAIN : ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        addr      <= addr + AW'(len << BSHIFT);
                        remaining <= remaining - len;
                        beat_cnt  <= 9'(len);
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt - 9'd1;
                        if (beat_cnt == 9'd1)
                            state <= (remaining != 32'd0) ? ADDR : DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding_next == 4'd0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aximm_burst_writer.sv
// tb/tb_aximm_burst_writer.sv - scoreboard bench for aximm_burst_writer
module tb_aximm_burst_writer;
    localparam int DW = 512;
    localparam int AW = 64;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    l;
    } aw_t;
    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } w_t;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [31:0]     total_beats = '0;
    logic            busy, done, error;
    logic [DW-1:0]   tdata = '0;
    logic            tvalid = 1'b0;
    logic            tready;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast, wvalid;
    logic            wready = 1'b0;
    logic [1:0]      bresp = 2'b00;
    logic            bvalid = 1'b0;
    logic            bready;

    always #5 clk = ~clk;

    aximm_burst_writer #(.DW(DW), .AW(AW), .MAX_BEATS(16), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .total_beats(total_beats), .busy(busy), .done(done), .error(error),
        .AXIS_IN_TDATA(tdata), .AXIS_IN_TVALID(tvalid), .AXIS_IN_TREADY(tready),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int aw_count = 0, w_count = 0, b_count = 0, done_count = 0, b_at_done = 0;
    int unsigned tx_count = 0;
    int unsigned exp_tx = 0;
    logic err_at_done = 1'b0, busy_at_done = 1'b0;
    bit b_hold = 0, wready_rand = 0, tvalid_rand = 0, awready_rand = 0;
    bit err_watch = 0, pend_aw = 0;
    logic [AW-1:0] pend_addr;
    logic [7:0]    pend_len;
    aw_t exp_aw[$];
    w_t  exp_w[$];
    int  b_due[$];
    logic [1:0] b_resp[$];
    logic [1:0] bresp_plan[$];
    aw_t ea;
    w_t  ew;

    function automatic logic [DW-1:0] pat(input int unsigned n);
        return {(DW/32){n ^ 32'hA5A5_0000}};
    endfunction

    // Slave and stream source: drive just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        awready = awready_rand ? 1'($urandom) : 1'b1;
        wready  = wready_rand ? 1'($urandom) : 1'b1;
        tvalid  = tvalid_rand ? 1'($urandom) : 1'b1;
        tdata   = pat(tx_count);
        if (!b_hold && b_due.size() > 0 && cycle >= b_due[0]) begin
            bvalid = 1'b1;
            bresp  = b_resp[0];
        end else begin
            bvalid = 1'b0;
            bresp  = 2'b00;
        end
    end

    // Monitor and scoreboard: sample on the falling edge.
    initial forever begin
        @(negedge clk);
        cycle++;
        if (!resetn) begin
            b_due.delete();
            b_resp.delete();
            pend_aw = 0;
        end else begin
            if (err_watch) begin
                checks++;
                if (error !== 1'b1) begin
                    errors++;
                    $display("FAIL error_sticky: error=%b required 1 at cycle %0d", error, cycle);
                end
            end
            if (pend_aw) begin
                checks++;
                if (!(awvalid === 1'b1 && awaddr === pend_addr && awlen === pend_len)) begin
                    errors++;
                    $display("FAIL aw_stable: valid=%b addr=%h len=%0d required 1/%h/%0d",
                             awvalid, awaddr, awlen, pend_addr, pend_len);
                end
            end
            pend_aw   = awvalid && !awready;
            pend_addr = awaddr;
            pend_len  = awlen;
            if (awvalid && awready) begin
                aw_count++;
                checks++;
                if (exp_aw.size() == 0) begin
                    errors++;
                    $display("FAIL aw_unexpected: addr=%h len=%0d required no AW", awaddr, awlen);
                end else begin
                    ea = exp_aw.pop_front();
                    if (awaddr !== ea.a || awlen !== ea.l) begin
                        errors++;
                        $display("FAIL aw_burst: addr=%h len=%0d required addr=%h len=%0d",
                                 awaddr, awlen, ea.a, ea.l);
                    end
                end
                checks++;
                if (awsize !== 3'd6 || awburst !== 2'b01) begin
                    errors++;
                    $display("FAIL aw_const: size=%0d burst=%0d required 6/1", awsize, awburst);
                end
            end
            if (tvalid && tready)
                tx_count++;
            if (wvalid && wready) begin
                w_count++;
                checks++;
                if (exp_w.size() == 0) begin
                    errors++;
                    $display("FAIL w_unexpected: last=%b required no W beat", wlast);
                end else begin
                    ew = exp_w.pop_front();
                    if (wdata !== ew.d || wlast !== ew.last || wstrb !== '1) begin
                        errors++;
                        $display("FAIL w_beat: data=%h last=%b required data=%h last=%b",
                                 wdata[31:0], wlast, ew.d[31:0], ew.last);
                    end
                end
                if (wlast) begin
                    b_due.push_back(cycle + 2);
                    b_resp.push_back(bresp_plan.size() > 0 ? bresp_plan.pop_front() : 2'b00);
                end
            end
            if (bvalid && bready) begin
                b_count++;
                if (bresp != 2'b00)
                    err_watch = 1;
                if (b_due.size() > 0) begin
                    void'(b_due.pop_front());
                    void'(b_resp.pop_front());
                end
            end
            if (done) begin
                done_count++;
                err_at_done  = error;
                busy_at_done = busy;
                b_at_done    = b_count;
                err_watch    = 0;
            end
        end
    end

    task automatic expect_burst(input logic [AW-1:0] a, input int n);
        aw_t e;
        w_t  w;
        e.a = a;
        e.l = 8'(n - 1);
        exp_aw.push_back(e);
        for (int i = 0; i < n; i++) begin
            w.d    = pat(exp_tx);
            w.last = (i == n - 1);
            exp_tx++;
            exp_w.push_back(w);
        end
    endtask

    task automatic start_xfer(input logic [AW-1:0] a, input logic [31:0] n);
        @(posedge clk);
        #1;
        base_addr   = a;
        total_beats = n;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_count == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_count == d0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, awvalid, wvalid, wlast, tready, bready} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: %b required 00000000",
                     {busy, done, error, awvalid, wvalid, wlast, tready, bready});
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bready !== 1'b1 || busy !== 1'b0 || awvalid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: bready=%b busy=%b awvalid=%b required 1/0/0", bready, busy, awvalid);
        end
    endtask

    task automatic test_basic();
        int d0 = done_count, a0 = aw_count, w0 = w_count, n = 0;
        exp_tx = tx_count;
        expect_burst(64'h1000, 16);
        expect_burst(64'h1400, 16);
        expect_burst(64'h1800, 8);
        start_xfer(64'h1000, 40);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || awvalid !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: busy=%b awvalid=%b required 1/1", busy, awvalid);
        end
        while (aw_count == a0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        start_xfer(64'h9000, 5);
        wait_done(d0, 600);
        repeat (5) @(negedge clk);
        checks++;
        if (done_count - d0 != 1 || aw_count - a0 != 3 || w_count - w0 != 40) begin
            errors++;
            $display("FAIL basic_counts: done=%0d aw=%0d w=%0d required 1/3/40",
                     done_count - d0, aw_count - a0, w_count - w0);
        end
        checks++;
        if (err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_state: error=%b busy=%b required 0/0", err_at_done, busy_at_done);
        end
        checks++;
        if (exp_aw.size() != 0 || exp_w.size() != 0) begin
            errors++;
            $display("FAIL basic_leftover: aw=%0d w=%0d required 0/0", exp_aw.size(), exp_w.size());
        end
    endtask

    task automatic test_4k_cross();
        int d0 = done_count, a0 = aw_count;
        exp_tx = tx_count;
        expect_burst(64'h0F80, 2);
        expect_burst(64'h1000, 8);
        start_xfer(64'h0F80, 10);
        wait_done(d0, 300);
        checks++;
        if (aw_count - a0 != 2 || exp_w.size() != 0) begin
            errors++;
            $display("FAIL cross_counts: aw=%0d wleft=%0d required 2/0", aw_count - a0, exp_w.size());
        end
    endtask

    task automatic test_outstanding();
        int d0 = done_count, a0 = aw_count, w0 = w_count, b0 = b_count, n = 0;
        bit stuck = 0;
        exp_tx = tx_count;
        for (int i = 0; i < 5; i++)
            expect_burst(64'h2000 + 64'(i) * 64'h400, 16);
        b_hold = 1;
        start_xfer(64'h2000, 80);
        while (w_count - w0 < 64 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) begin
            @(negedge clk);
            if (awvalid)
                stuck = 1;
        end
        checks++;
        if (aw_count - a0 != 4 || stuck || b_count != b0) begin
            errors++;
            $display("FAIL outstanding_limit: aw=%0d awvalid_seen=%0d b=%0d required 4/0/0",
                     aw_count - a0, stuck, b_count - b0);
        end
        b_hold = 0;
        wait_done(d0, 500);
        checks++;
        if (aw_count - a0 != 5 || b_at_done - b0 != 5 || done_count - d0 != 1) begin
            errors++;
            $display("FAIL outstanding_release: aw=%0d b_at_done=%0d done=%0d required 5/5/1",
                     aw_count - a0, b_at_done - b0, done_count - d0);
        end
    endtask

    task automatic test_error();
        int d0 = done_count;
        exp_tx = tx_count;
        awready_rand = 1;
        expect_burst(64'h3000, 16);
        expect_burst(64'h3400, 16);
        expect_burst(64'h3800, 16);
        bresp_plan.push_back(2'b00);
        bresp_plan.push_back(2'b10);
        bresp_plan.push_back(2'b00);
        start_xfer(64'h3000, 48);
        wait_done(d0, 800);
        @(negedge clk);
        checks++;
        if (err_at_done !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL error_set: at_done=%b idle=%b required 1/1", err_at_done, error);
        end
        d0 = done_count;
        expect_burst(64'h5000, 16);
        start_xfer(64'h5000, 16);
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: error=%b required 0", error);
        end
        wait_done(d0, 400);
        checks++;
        if (err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL error_clean_run: error=%b required 0", err_at_done);
        end
        awready_rand = 0;
    endtask

    task automatic test_zero_length();
        int d0 = done_count, a0 = aw_count;
        start_xfer(64'h4000, 0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || awvalid !== 1'b0) begin
            errors++;
            $display("FAIL zero_first: busy=%b done=%b awvalid=%b required 1/0/0", busy, done, awvalid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b required 1/0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || aw_count != a0 || done_count - d0 != 1) begin
            errors++;
            $display("FAIL zero_after: done=%b busy=%b aw=%0d pulses=%0d required 0/0/0/1",
                     done, busy, aw_count - a0, done_count - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0 = done_count, w0 = w_count, n = 0;
        exp_tx = tx_count;
        wready_rand = 1;
        tvalid_rand = 1;
        for (int i = 0; i < 4; i++)
            expect_burst(64'h6000 + 64'(i) * 64'h400, 16);
        start_xfer(64'h6000, 64);
        while (w_count - w0 < 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        tvalid_rand = 0;
        @(posedge clk);
        #2;
        checks++;
        if (wvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_data: wvalid=%b busy=%b required 1/1", wvalid, busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({wvalid, awvalid, busy, bready, tready} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: %b required 00000", {wvalid, awvalid, busy, bready, tready});
        end
        repeat (3) @(posedge clk);
        exp_aw.delete();
        exp_w.delete();
        bresp_plan.delete();
        #1;
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (done_count != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: pulses=%0d busy=%b required 0/0", done_count - d0, busy);
        end
        tvalid_rand = 1;
        exp_tx = tx_count;
        expect_burst(64'h7000, 16);
        start_xfer(64'h7011, 16);
        wait_done(d0, 600);
        checks++;
        if (done_count - d0 != 1 || exp_aw.size() != 0 || exp_w.size() != 0) begin
            errors++;
            $display("FAIL reset_recover: done=%0d awleft=%0d wleft=%0d required 1/0/0",
                     done_count - d0, exp_aw.size(), exp_w.size());
        end
        wready_rand = 0;
        tvalid_rand = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_4k_cross();
        test_outstanding();
        test_error();
        test_zero_length();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
